gpio_irq_capture: RTL and testbench

//  Input-side companion to the GPIO port: samples up to 32 raw input pins and

---
 rtl/gpio_irq_capture.sv | 106 ++++++++++
 tb/tb_gpio_irq_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_capture.sv
// GPIO input capture: 2-flop sync, per-pin debounce, edge/level events into sticky W1C pending bits + IRQ.
// Optional level-triggered mode is enabled by defining GPIO_IRQ_LEVEL_EN (adds i_WEL and a level-mode register).
module gpio_irq_capture #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             i_Clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [31:0]      i_DD,
  input  logic             i_WER,
  input  logic             i_WEF,
  input  logic             i_WEP,
`ifdef GPIO_IRQ_LEVEL_EN
  input  logic             i_WEL,
`endif
  output logic [WIDTH-1:0] o_DIN,
  output logic [WIDTH-1:0] o_PEND,
  output logic             o_IRQ
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            din_q, din_d, din_prev_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0]            pend_q, pend_d;
  logic                        irq_q, irq_d;
  logic [WIDTH-1:0]            wr_data;
  logic [WIDTH-1:0]            clr_mask, edge_set, set_mask;
`ifdef GPIO_IRQ_LEVEL_EN
  logic [WIDTH-1:0]            lvl_q, lvl_d, lvl_set;
`endif

  assign wr_data = i_DD[WIDTH-1:0];

  // Debounce: a differing synchronized level must persist DEBOUNCE samples before acceptance.
  always_comb begin
    cnt_d = cnt_q;
    din_d = din_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == din_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        din_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Event generation, pending update (set beats clear) and enable register loads.
  always_comb begin
    edge_set  = (din_q & ~din_prev_q & rise_en_q) | (~din_q & din_prev_q & fall_en_q);
`ifdef GPIO_IRQ_LEVEL_EN
    lvl_set   = (din_q & rise_en_q) | (~din_q & fall_en_q);
    set_mask  = (lvl_q & lvl_set) | (~lvl_q & edge_set);
    lvl_d     = i_WEL ? wr_data : lvl_q;
`else
    set_mask  = edge_set;
`endif
    clr_mask  = i_WEP ? wr_data : '0;
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    irq_d     = |pend_d;
    rise_en_d = i_WER ? wr_data : rise_en_q;
    fall_en_d = i_WEF ? wr_data : fall_en_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      din_q      <= '0;
      din_prev_q <= '0;
      cnt_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
`ifdef GPIO_IRQ_LEVEL_EN
      lvl_q      <= '0;
`endif
    end else begin
      sync1_q    <= i_pins;
      sync2_q    <= sync1_q;
      din_q      <= din_d;
      din_prev_q <= din_q;
      cnt_q      <= cnt_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
`ifdef GPIO_IRQ_LEVEL_EN
      lvl_q      <= lvl_d;
`endif
    end
  end

  assign o_DIN  = din_q;
  assign o_PEND = pend_q;
  assign o_IRQ  = irq_q;

endmodule

// File: tb/tb_gpio_irq_capture.sv
// Self-checking bench for gpio_irq_capture: directed scenarios plus random traffic against a behavioural model.
module tb_gpio_irq_capture;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] pins = '0;
  logic [31:0]  dd = '0;
  logic         wer = 1'b0, wef = 1'b0, wep = 1'b0;
`ifdef GPIO_IRQ_LEVEL_EN
  logic         wel = 1'b0;
  logic [W-1:0] m_lvl = '0;
`endif
  logic [W-1:0] din, pend;
  logic         irq;

  int n_pass = 0;
  int n_total = 0;

  // Model state: accepted level, its previous value, pending, enables, pin history.
  logic [W-1:0] m_din = '0, m_prev = '0, m_pend = '0, m_ren = '0, m_fen = '0;
  logic         m_irq = 1'b0;
  logic [W-1:0] hist[$];

  gpio_irq_capture #(.WIDTH(W), .DEBOUNCE(D), .CNT_W(3)) dut (
    .i_Clk (clk),
    .i_rst (rst),
    .i_pins(pins),
    .i_DD  (dd),
    .i_WER (wer),
    .i_WEF (wef),
    .i_WEP (wep),
`ifdef GPIO_IRQ_LEVEL_EN
    .i_WEL (wel),
`endif
    .o_DIN (din),
    .o_PEND(pend),
    .o_IRQ (irq)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the model from current inputs, then sample DUT 1ns after the edge.
  // A pin level is accepted once the synchronized value (pin seen two edges ago) has
  // disagreed with the accepted level for D consecutive edges.
  task automatic tick();
    logic [W-1:0] nd, setm, clr;
    bit all_diff;
    if (rst) begin
      m_din = '0; m_prev = '0; m_pend = '0; m_irq = 1'b0; m_ren = '0; m_fen = '0;
`ifdef GPIO_IRQ_LEVEL_EN
      m_lvl = '0;
`endif
      hist.delete();
      for (int k = 0; k < int'(D) + 1; k++) hist.push_back('0);
    end else begin
      nd = m_din;
      for (int b = 0; b < int'(W); b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(D); j++)
          if (hist[hist.size() - 2 - j][b] == m_din[b]) all_diff = 1'b0;
        if (all_diff) nd[b] = ~m_din[b];
      end
      setm = (m_din & ~m_prev & m_ren) | (~m_din & m_prev & m_fen);
`ifdef GPIO_IRQ_LEVEL_EN
      setm = (m_lvl & ((m_din & m_ren) | (~m_din & m_fen))) | (~m_lvl & setm);
      if (wel) m_lvl = dd[W-1:0];
`endif
      clr    = wep ? dd[W-1:0] : '0;
      m_pend = (m_pend & ~clr) | setm;
      m_irq  = (m_pend != '0);
      if (wer) m_ren = dd[W-1:0];
      if (wef) m_fen = dd[W-1:0];
      m_prev = m_din;
      m_din  = nd;
      hist.push_back(pins);
      if (hist.size() > int'(D) + 1) void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wer = 1'b0; wef = 1'b0; wep = 1'b0; dd = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pins = 32'hFFFF_FFFF; dd = 32'hFFFF_FFFF; wer = 1'b1; wef = 1'b1; wep = 1'b1;
    rst = 1'b1;
    tick(); tick();
    n_total++; if (din !== '0)  $display("FAIL reset_din got %h exp 0", din);  else n_pass++;
    n_total++; if (pend !== '0) $display("FAIL reset_pend got %h exp 0", pend); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq);  else n_pass++;
    rst = 1'b0; wer = 1'b0; wef = 1'b0; wep = 1'b0; pins = '0;
  endtask

  task automatic test_rise_latency();
    do_reset();
    wer = 1'b1; dd = 32'h1; tick(); wer = 1'b0;
    pins = 32'h1;
    for (int c = 1; c <= 5; c++) tick();
    n_total++; if (din[0] !== 1'b0) $display("FAIL rise_din_c5 got %b exp 0", din[0]); else n_pass++;
    tick();
    n_total++; if (din[0] !== 1'b1) $display("FAIL rise_din_c6 got %b exp 1", din[0]); else n_pass++;
    n_total++; if (pend !== '0) $display("FAIL rise_pend_c6 got %h exp 0", pend); else n_pass++;
    tick();
    n_total++; if (pend !== 32'h1 || irq !== 1'b1)
      $display("FAIL rise_pend_c7 got pend=%h irq=%b exp pend=1 irq=1", pend, irq); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    wer = 1'b1; dd = 32'hFFFF_FFFF; tick(); wer = 1'b0;
    pins = 32'h2; tick(); tick(); tick();
    pins = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_total++; if (din[1] !== 1'b0 || pend !== '0)
        $display("FAIL glitch_c%0d got din1=%b pend=%h exp 0/0", c, din[1], pend); else n_pass++;
    end
  endtask

  task automatic test_w1c();
    do_reset();
    wer = 1'b1; dd = 32'h3; tick(); wer = 1'b0;
    pins = 32'h3;
    for (int c = 0; c < 8; c++) tick();
    n_total++; if (pend !== 32'h3 || irq !== 1'b1)
      $display("FAIL w1c_setup got pend=%h irq=%b exp 3/1", pend, irq); else n_pass++;
    wep = 1'b1; dd = 32'h1; tick();
    n_total++; if (pend !== 32'h2 || irq !== 1'b1)
      $display("FAIL w1c_first got pend=%h irq=%b exp 2/1", pend, irq); else n_pass++;
    dd = 32'h2; tick(); wep = 1'b0;
    n_total++; if (pend !== '0 || irq !== 1'b0)
      $display("FAIL w1c_last got pend=%h irq=%b exp 0/0", pend, irq); else n_pass++;
  endtask

  task automatic test_set_wins();
    do_reset();
    wef = 1'b1; dd = 32'h4; tick(); wef = 1'b0;
    pins = 32'h4;
    for (int c = 0; c < 8; c++) tick();
    n_total++; if (din[2] !== 1'b1 || pend !== '0)
      $display("FAIL setwins_high got din2=%b pend=%h exp 1/0", din[2], pend); else n_pass++;
    pins = '0;
    for (int c = 0; c < 6; c++) tick();
    n_total++; if (din[2] !== 1'b0 || pend !== '0)
      $display("FAIL setwins_fall got din2=%b pend=%h exp 0/0", din[2], pend); else n_pass++;
    wep = 1'b1; dd = 32'h4; tick(); wep = 1'b0;
    n_total++; if (pend !== 32'h4 || irq !== 1'b1)
      $display("FAIL setwins_pend got pend=%h irq=%b exp 4/1", pend, irq); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wer = 1'b1; dd = 32'h8; tick(); wer = 1'b0;
    pins = 32'h8; tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_total++; if (din !== '0 || pend !== '0 || irq !== 1'b0)
      $display("FAIL rstmid_clear got din=%h pend=%h irq=%b exp 0", din, pend, irq); else n_pass++;
    for (int c = 0; c < 5; c++) tick();
    n_total++; if (din[3] !== 1'b0) $display("FAIL rstmid_c5 got %b exp 0", din[3]); else n_pass++;
    tick();
    n_total++; if (din[3] !== 1'b1 || pend !== '0)
      $display("FAIL rstmid_c6 got din3=%b pend=%h exp 1/0", din[3], pend); else n_pass++;
  endtask

`ifdef GPIO_IRQ_LEVEL_EN
  task automatic test_level();
    do_reset();
    wer = 1'b1; wel = 1'b1; dd = 32'h10; tick(); wer = 1'b0; wel = 1'b0;
    pins = 32'h10;
    for (int c = 0; c < 8; c++) tick();
    n_total++; if (pend[4] !== 1'b1) $display("FAIL level_set got %b exp 1", pend[4]); else n_pass++;
    wep = 1'b1; dd = 32'h10; tick(); wep = 1'b0;
    n_total++; if (pend[4] !== 1'b1) $display("FAIL level_reassert got %b exp 1", pend[4]); else n_pass++;
    pins = '0;
    for (int c = 0; c < 8; c++) tick();
    wep = 1'b1; tick(); wep = 1'b0; tick();
    n_total++; if (pend[4] !== 1'b0 || irq !== 1'b0)
      $display("FAIL level_clear got pend4=%b irq=%b exp 0/0", pend[4], irq); else n_pass++;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      pins = pins ^ ($urandom & $urandom & $urandom);
      rst  = ($urandom_range(0, 199) == 0);
      wer  = ($urandom_range(0, 15) == 0);
      wef  = ($urandom_range(0, 15) == 0);
      wep  = ($urandom_range(0, 3) == 0);
`ifdef GPIO_IRQ_LEVEL_EN
      wel  = ($urandom_range(0, 31) == 0);
`endif
      dd   = $urandom;
      tick();
      n_total++; if (din !== m_din)   $display("FAIL rand_din c%0d got %h exp %h", c, din, m_din);    else n_pass++;
      n_total++; if (pend !== m_pend) $display("FAIL rand_pend c%0d got %h exp %h", c, pend, m_pend); else n_pass++;
      n_total++; if (irq !== m_irq)   $display("FAIL rand_irq c%0d got %b exp %b", c, irq, m_irq);    else n_pass++;
    end
    rst = 1'b0; wer = 1'b0; wef = 1'b0; wep = 1'b0;
`ifdef GPIO_IRQ_LEVEL_EN
    wel = 1'b0;
`endif
  endtask

  initial begin
    for (int k = 0; k < int'(D) + 1; k++) hist.push_back('0);
    test_reset();
    test_rise_latency();
    test_glitch();
    test_w1c();
    test_set_wins();
    test_reset_mid();
`ifdef GPIO_IRQ_LEVEL_EN
    test_level();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
